// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg: constants and helpers shared by the stream/select mux blocks
// Revision: 1.0
// ============================================================================
package mux_pkg;

  localparam int MUX_MODE_BEAT   = 0;
  localparam int MUX_MODE_PACKET = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter: combinational round-robin grant with an optional forced lock
// Revision: 1.0
// ============================================================================
module rr_arbiter import mux_pkg::*; #(
  parameter int N    = 4,
  parameter int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            lock,
  input  logic [SELW-1:0] lock_ch,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return SELW'(sum);
  endfunction

  // Descending scan so the candidate closest to ptr is written last and wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (lock) begin
      grant       = lock_ch;
      grant_valid = req[lock_ch];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[wrap_idx(ptr, k)]) begin
          grant       = wrap_idx(ptr, k);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
// rr_stream_mux: N-channel round-robin valid/ready stream mux, registered output
// Revision: 1.0
// ============================================================================
module rr_stream_mux import mux_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int N      = 4,
  parameter int PACKET = MUX_MODE_BEAT,
  parameter int SELW   = clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  localparam bit c_packet_mode = (PACKET == MUX_MODE_PACKET);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_sel;
  logic [SELW-1:0]  r_ptr;
  logic             r_lock;
  logic [SELW-1:0]  r_lock_ch;

  logic             w_load_en;
  logic             w_grant_valid;
  logic             w_xfer;
  logic             w_beat_last;
  logic [SELW-1:0]  w_grant;
  logic [SELW-1:0]  w_ptr_next;
  logic [WIDTH-1:0] w_beat_data;

  assign w_load_en = !r_out_valid || out_ready;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (r_ptr),
    .lock        (r_lock),
    .lock_ch     (r_lock_ch),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // grant_valid already implies the granted channel is valid, so this is the transfer.
  assign w_xfer      = w_load_en && w_grant_valid;
  assign w_beat_last = in_last[w_grant];
  assign w_beat_data = in_data[w_grant*WIDTH +: WIDTH];
  assign w_ptr_next  = (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_ready
    assign in_ready[i] = w_xfer && (w_grant == SELW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
    end else begin
      if (w_load_en) r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_beat_data;
        r_out_last <= w_beat_last;
        r_out_sel  <= w_grant;
        if (!c_packet_mode || w_beat_last) r_ptr <= w_ptr_next;
        // In packet mode a non-final beat pins the grant to its channel.
        if (c_packet_mode) begin
          r_lock <= !w_beat_last;
          if (!w_beat_last) r_lock_ch <= w_grant;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// Scoreboard bench: a beat-mode and a packet-mode instance driven by directed vectors.
module tb_rr_stream_mux;
  import mux_pkg::*;

  localparam int W   = 32;
  localparam int NCH = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [NCH-1:0]   v0, l0, rdy0, v1, l1, rdy1;
  logic [NCH*W-1:0] d0, d1;
  logic             ov0, ol0, ordy0, ov1, ol1, ordy1;
  logic [W-1:0]     od0, od1;
  logic [1:0]       os0, os1;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0, e1;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(W), .N(NCH), .PACKET(MUX_MODE_BEAT)) u_dut_beat (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_last(l0), .in_ready(rdy0),
    .out_valid(ov0), .out_data(od0), .out_last(ol0), .out_sel(os0), .out_ready(ordy0)
  );

  rr_stream_mux #(.WIDTH(W), .N(NCH), .PACKET(MUX_MODE_PACKET)) u_dut_pkt (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_last(l1), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_sel(os1), .out_ready(ordy1)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  function automatic void push0(input logic [W-1:0] d, input int s, input logic l);
    beat_t b;
    b.data = d; b.sel = s[1:0]; b.last = l;
    q0.push_back(b);
  endfunction

  function automatic void push1(input logic [W-1:0] d, input int s, input logic l);
    beat_t b;
    b.data = d; b.sel = s[1:0]; b.last = l;
    q1.push_back(b);
  endfunction

  // Monitors: a beat leaves the output register at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && ov0 && ordy0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL beat_out extra: got data=%h sel=%0d last=%0d, want no beat", od0, os0, ol0);
      end else begin
        e0 = q0.pop_front();
        if ({od0, os0, ol0} !== e0) begin
          errors++;
          $display("FAIL beat_out: got data=%h sel=%0d last=%0d, want data=%h sel=%0d last=%0d",
                   od0, os0, ol0, e0.data, e0.sel, e0.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && ordy1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL pkt_out extra: got data=%h sel=%0d last=%0d, want no beat", od1, os1, ol1);
      end else begin
        e1 = q1.pop_front();
        if ({od1, os1, ol1} !== e1) begin
          errors++;
          $display("FAIL pkt_out: got data=%h sel=%0d last=%0d, want data=%h sel=%0d last=%0d",
                   od1, os1, ol1, e1.data, e1.sel, e1.last);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish by 20000ns, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NCH-1:0] oh;
    rst_n = 1'b0;
    v0 = '0; l0 = '0; d0 = '0; ordy0 = 1'b0;
    v1 = '0; l1 = '0; d1 = '0; ordy1 = 1'b0;
    @(negedge clk);
    chk("reset_vals_beat", {ov0, ol0, os0, rdy0, od0}, 64'h0);
    chk("reset_vals_pkt", {ov1, ol1, os1, rdy1, od1}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_beat", {ov0, rdy0, od0}, 64'h0);
      chk("idle_pkt", {ov1, rdy1, od1}, 64'h0);
    end

    // Fairness: all four channels valid, one beat per cycle in order 0,1,2,3,...
    @(posedge clk); #1;
    ordy0 = 1'b1; v0 = 4'b1111; l0 = '0;
    for (int i = 0; i < NCH; i++) d0[i*W +: W] = W'(i);
    for (int k = 0; k < 8; k++) push0(W'(k % 4), k % 4, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      oh = 4'b0001 << (k % 4);
      chk("fair_ready", {ov0, rdy0}, {(k > 0), oh});
      @(posedge clk);
    end
    #1 v0 = '0;

    // Backpressure: channel 2 holds DEADBEEF while the consumer stalls.
    @(posedge clk); #1;
    ordy0 = 1'b0; v0 = 4'b0100; d0[2*W +: W] = 32'hDEADBEEF; l0 = 4'b0100;
    push0(32'hDEADBEEF, 2, 1'b1);
    @(negedge clk);
    chk("bp_first_ready", rdy0, 4'b0100);
    @(posedge clk); #1;
    d0[2*W +: W] = 32'h12345678; l0 = 4'b0000;
    push0(32'h12345678, 2, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", {ov0, ol0, os0, rdy0, od0}, {1'b1, 1'b1, 2'd2, 4'b0000, 32'hDEADBEEF});
    end
    @(posedge clk); #1 ordy0 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", rdy0, 4'b0100);
    @(posedge clk); #1 v0 = '0;
    @(negedge clk);
    chk("bp_next_loaded", {ov0, od0}, {1'b1, 32'h12345678});

    // Wrap-around: last grant was channel 2, so ptr is 3.
    @(posedge clk); #1;
    v0 = 4'b1010; d0[3*W +: W] = 32'h33; d0[1*W +: W] = 32'h11; l0 = '0;
    push0(32'h33, 3, 1'b0);
    @(negedge clk);
    chk("wrap_ch3", rdy0, 4'b1000);
    @(posedge clk); #1;
    push0(32'h11, 1, 1'b0);
    @(negedge clk);
    chk("wrap_ch1", rdy0, 4'b0010);
    @(posedge clk); #1;
    v0 = 4'b1110; d0[2*W +: W] = 32'h22;
    push0(32'h22, 2, 1'b0);
    @(negedge clk);
    chk("wrap_ptr2", rdy0, 4'b0100);
    @(posedge clk); #1 v0 = '0;

    // Packet lock: single beat on ch0 moves ptr to 1, then a gapped 3-beat packet on ch1.
    @(posedge clk); #1;
    ordy1 = 1'b1; v1 = 4'b0001; d1[0 +: W] = 32'hA0; l1 = 4'b0001;
    push1(32'hA0, 0, 1'b1);
    @(negedge clk);
    chk("pkt_single_ch0", rdy1, 4'b0001);
    @(posedge clk); #1;
    v1 = 4'b0011; d1[1*W +: W] = 32'hB1; l1 = 4'b0001;
    push1(32'hB1, 1, 1'b0);
    @(negedge clk);
    chk("pkt_beat1", rdy1, 4'b0010);
    @(posedge clk); #1;
    v1 = 4'b0001;
    @(negedge clk);
    chk("pkt_gap_locked", rdy1, 4'b0000);
    @(posedge clk); #1;
    v1 = 4'b0011; d1[1*W +: W] = 32'hB2;
    push1(32'hB2, 1, 1'b0);
    @(negedge clk);
    chk("pkt_beat2", rdy1, 4'b0010);
    @(posedge clk); #1;
    d1[1*W +: W] = 32'hB3; l1 = 4'b0011;
    push1(32'hB3, 1, 1'b1);
    @(negedge clk);
    chk("pkt_beat3", rdy1, 4'b0010);
    @(posedge clk); #1;
    v1 = 4'b0001;
    push1(32'hA0, 0, 1'b1);
    @(negedge clk);
    chk("pkt_unlock_ch0", rdy1, 4'b0001);
    @(posedge clk); #1 v1 = '0;

    // Reset mid-packet on ch2 while the first beat sits stalled in the output register.
    @(posedge clk); #1;
    ordy1 = 1'b0; v1 = 4'b0100; d1[2*W +: W] = 32'hC1; l1 = '0;
    @(negedge clk);
    chk("rst_pkt_beat1_ready", rdy1, 4'b0100);
    @(posedge clk); #1 v1 = '0;
    @(negedge clk);
    chk("rst_pkt_beat1_held", {ov1, os1, od1}, {1'b1, 2'd2, 32'hC1});
    #1 rst_n = 1'b0;
    #1 chk("rst_async_clear", {ov1, ol1, os1, od1}, 64'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1;
    ordy1 = 1'b1; v1 = 4'b0101; l1 = 4'b0101;
    d1[0 +: W] = 32'hD0; d1[2*W +: W] = 32'hD2;
    push1(32'hD0, 0, 1'b1);
    rst_n = 1'b1;
    #1 chk("rst_restart_ch0", rdy1, 4'b0001);
    @(posedge clk); #1;
    v1 = 4'b0100;
    push1(32'hD2, 2, 1'b1);
    @(negedge clk);
    chk("rst_then_ch2", rdy1, 4'b0100);
    @(posedge clk); #1 v1 = '0;

    repeat (3) @(negedge clk);
    chk("beat_queue_drained", 64'(q0.size()), 64'h0);
    chk("pkt_queue_drained", 64'(q1.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
